// File: rtl/hazard_pkg.sv
// Shared types and constants for the issue-side hazard scoreboard:
// register index type, in-flight pipe entry, and the source/entry match helper.
package hazard_pkg;

    localparam int DEPTH_DEFAULT = 3;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t X0 = 5'd0;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
    } inflight_t;

    localparam inflight_t INFLIGHT_EMPTY = '{valid: 1'b0, rd: 5'd0};

    // A used, non-x0 source collides with a valid pending write to the same index.
    function automatic logic src_match(input reg_idx_t src, input logic used, input inflight_t entry);
        return used && (src != X0) && entry.valid && (entry.rd == src);
    endfunction

endpackage

// File: rtl/inflight_pipe.sv
// Destination-register delay line: DEPTH-stage shift register of in-flight
// entries. Stage index 0 is the youngest, DEPTH-1 the oldest (writeback).
// kill_mask[i] squashes the entry leaving stage i as it moves to stage i+1;
// the oldest stage has no kill bit because it retires unconditionally.
module inflight_pipe
    import hazard_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  inflight_t             load,
    input  logic      [DEPTH-2:0] kill_mask,
    output inflight_t [DEPTH-1:0] stages
);

    inflight_t [DEPTH-1:0] stage_r;

    // Shift every cycle; reset empties the whole pipe immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= INFLIGHT_EMPTY;
            end
        end else begin
            stage_r[0] <= load;
            for (int i = 1; i < DEPTH; i++) begin
                if (kill_mask[i-1]) begin
                    stage_r[i] <= INFLIGHT_EMPTY;
                end else begin
                    stage_r[i] <= stage_r[i-1];
                end
            end
        end
    end

    assign stages = stage_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard controller: tracks pending destination writes through the
// in-flight pipe, blocks issue on read-after-write collisions or flush, drives
// the register-file write port at writeback and counts stall cycles.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int WB_BYPASS = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_use_rs1,
    input  logic        issue_use_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_we,
    input  logic        flush,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [15:0] stall_cnt
);

    // With a forwarding register file the writeback stage is already visible
    // to readers, so only the younger stages need comparing.
    localparam int CMP_STAGES = (WB_BYPASS != 0) ? (DEPTH - 1) : DEPTH;

    inflight_t [DEPTH-1:0] stages_s;
    inflight_t             load_s;
    logic      [DEPTH-2:0] kill_mask_s;
    logic                  hazard_s;
    logic                  accept_s;
    logic      [15:0]      stall_cnt_r;

    inflight_pipe #(
        .DEPTH (DEPTH)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .kill_mask (kill_mask_s),
        .stages    (stages_s)
    );

    // Compare both used sources against every pending write in the compared stages.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < CMP_STAGES) begin
                if (src_match(issue_rs1, issue_use_rs1, stages_s[i]) ||
                    src_match(issue_rs2, issue_use_rs2, stages_s[i])) begin
                    hazard_s = 1'b1;
                end else begin
                    hazard_s = hazard_s;
                end
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    assign issue_ready = !hazard_s && !flush;
    assign accept_s    = issue_valid && issue_ready;

    // Flush squashes everything younger than writeback; the oldest entry still retires.
    assign kill_mask_s = {(DEPTH-1){flush}};

    // Build the stage-1 entry: x0 and non-writing instructions are never tracked,
    // and an idle cycle inserts an empty bubble.
    always_comb begin
        load_s = INFLIGHT_EMPTY;
        if (accept_s) begin
            load_s.valid = issue_we && (issue_rd != X0);
            load_s.rd    = issue_rd;
        end else begin
            load_s = INFLIGHT_EMPTY;
        end
    end

    // Saturating count of cycles in which decode presented work but issue was blocked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 16'd0;
        end else if (issue_valid && !issue_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Writeback port is the oldest pipe stage, which is itself a register.
    assign wb_valid  = stages_s[DEPTH-1].valid;
    assign wb_rd     = stages_s[DEPTH-1].rd;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one instance without writeback
// forwarding (nb) and one with it (bp), both DEPTH=3, sharing the same stimulus.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_use_rs1;
    logic        issue_use_rs2;
    logic [4:0]  issue_rd;
    logic        issue_we;
    logic        flush;

    logic        ready_nb, ready_bp;
    logic        wbv_nb, wbv_bp;
    logic [4:0]  wbrd_nb, wbrd_bp;
    logic [15:0] cnt_nb, cnt_bp;

    int checks_s;
    int failures_s;

    hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(0)) dut_nb (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (ready_nb),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_rd      (issue_rd),
        .issue_we      (issue_we),
        .flush         (flush),
        .wb_valid      (wbv_nb),
        .wb_rd         (wbrd_nb),
        .stall_cnt     (cnt_nb)
    );

    hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1)) dut_bp (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (ready_bp),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_rd      (issue_rd),
        .issue_we      (issue_we),
        .flush         (flush),
        .wb_valid      (wbv_bp),
        .wb_rd         (wbrd_bp),
        .stall_cnt     (cnt_bp)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_s++;
        if (obs !== exp) begin
            failures_s++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid   = 1'b0;
        issue_rs1     = 5'd0;
        issue_rs2     = 5'd0;
        issue_use_rs1 = 1'b0;
        issue_use_rs2 = 1'b0;
        issue_rd      = 5'd0;
        issue_we      = 1'b0;
        flush         = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writer(input logic [4:0] rd);
        idle();
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_we    = 1'b1;
    endtask

    initial begin
        checks_s   = 0;
        failures_s = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        #1;
        check("rst_wbv_nb", {31'd0, wbv_nb}, 32'd0);
        check("rst_wbrd_nb", {27'd0, wbrd_nb}, 32'd0);
        check("rst_cnt_nb", {16'd0, cnt_nb}, 32'd0);
        check("rst_ready_nb", {31'd0, ready_nb}, 32'd1);
        check("rst_ready_bp", {31'd0, ready_bp}, 32'd1);
        tick();
        reset = 1'b0;

        // Single writer rd=5: writeback exactly three cycles later, never stalls.
        writer(5'd5);
        #1;
        check("t1_ready_c0", {31'd0, ready_nb}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            idle();
            #1;
            check($sformatf("t1_wbv_c%0d", k), {31'd0, wbv_nb}, (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("t1_ready_c%0d", k), {31'd0, ready_nb}, 32'd1);
        end
        check("t1_wbv_bp_c4", {31'd0, wbv_bp}, 32'd0);

        // Writer rd=7 then dependent reader of x7: 3 stalls without forwarding, 2 with.
        tick();
        writer(5'd7);
        tick();
        idle();
        issue_valid   = 1'b1;
        issue_rs1     = 5'd7;
        issue_use_rs1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("t2_ready_nb_c%0d", k), {31'd0, ready_nb}, (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("t2_ready_bp_c%0d", k), {31'd0, ready_bp}, (k >= 3) ? 32'd1 : 32'd0);
            if (k == 3) begin
                check("t2_wbv_c3", {31'd0, wbv_nb}, 32'd1);
                check("t2_wbrd_c3", {27'd0, wbrd_nb}, 32'd7);
            end
            tick();
        end
        idle();
        #1;
        check("t2_cnt_nb", {16'd0, cnt_nb}, 32'd3);
        check("t2_cnt_bp", {16'd0, cnt_bp}, 32'd2);

        // x0 writer then x0 reader: no tracking, no stall, no writeback.
        tick();
        writer(5'd0);
        tick();
        idle();
        issue_valid   = 1'b1;
        issue_rs1     = 5'd0;
        issue_use_rs1 = 1'b1;
        #1;
        check("t3_ready_x0", {31'd0, ready_nb}, 32'd1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            idle();
            #1;
            check($sformatf("t3_wbv_c%0d", k), {31'd0, wbv_nb}, 32'd0);
        end
        check("t3_cnt_nb", {16'd0, cnt_nb}, 32'd3);

        // Writer rd=8 then reader with rs2=8 but use_rs2=0: unused source never stalls.
        tick();
        writer(5'd8);
        tick();
        idle();
        issue_valid = 1'b1;
        issue_rs2   = 5'd8;
        #1;
        check("t3b_unused_rs2", {31'd0, ready_nb}, 32'd1);
        issue_use_rs2 = 1'b1;
        #1;
        check("t3b_used_rs2", {31'd0, ready_nb}, 32'd0);
        issue_use_rs2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            idle();
        end

        // rd=2, rd=3, rd=4 back to back, flush with a new instruction presented:
        // rd=2 (oldest) still writes back, rd=3/4 and the flush-cycle instruction vanish.
        writer(5'd2);
        tick();
        writer(5'd3);
        tick();
        writer(5'd4);
        tick();
        writer(5'd6);
        flush = 1'b1;
        #1;
        check("t4_wbv_flush", {31'd0, wbv_nb}, 32'd1);
        check("t4_wbrd_flush", {27'd0, wbrd_nb}, 32'd2);
        check("t4_ready_flush", {31'd0, ready_nb}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            idle();
            #1;
            check($sformatf("t4_wbv_c%0d", k), {31'd0, wbv_nb}, 32'd0);
            check($sformatf("t4_ready_c%0d", k), {31'd0, ready_nb}, 32'd1);
        end
        check("t4_cnt_nb", {16'd0, cnt_nb}, 32'd4);
        check("t4_cnt_bp", {16'd0, cnt_bp}, 32'd3);

        // Three valid entries, asynchronous reset mid-cycle: writeback drops at once,
        // the instruction presented during reset is not accepted.
        tick();
        writer(5'd10);
        tick();
        writer(5'd11);
        tick();
        writer(5'd12);
        tick();
        idle();
        #1;
        check("t5_wbv_before", {31'd0, wbv_nb}, 32'd1);
        check("t5_wbrd_before", {27'd0, wbrd_nb}, 32'd10);
        #1;
        reset = 1'b1;
        #1;
        check("t5_wbv_async", {31'd0, wbv_nb}, 32'd0);
        check("t5_cnt_async", {16'd0, cnt_nb}, 32'd0);
        tick();
        writer(5'd13);
        tick();
        reset = 1'b0;
        idle();
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("t5_wbv_after_c%0d", k), {31'd0, wbv_nb}, 32'd0);
            tick();
        end
        check("t5_cnt_after", {16'd0, cnt_nb}, 32'd0);

        // Permanent block via flush: counter climbs to 0xFFFF and stays there.
        issue_valid = 1'b1;
        flush       = 1'b1;
        repeat (65534) tick();
        #1;
        check("t6_cnt_fffe", {16'd0, cnt_nb}, 32'h0000FFFE);
        repeat (100) tick();
        #1;
        check("t6_cnt_sat_nb", {16'd0, cnt_nb}, 32'h0000FFFF);
        check("t6_cnt_sat_bp", {16'd0, cnt_bp}, 32'h0000FFFF);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
        $finish;
    end

endmodule
